// File: rtl/mlp_fe_pkg.sv
// Shared types and default geometry for the MLP sensor front-end.
package mlp_fe_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_REQ    = 3'd2,
      ST_WAIT   = 3'd3,
      ST_EVAL   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   localparam int unsigned N_FEAT_DEF = 6;
   localparam int unsigned FEAT_W_DEF = 4;
   localparam int unsigned ADC_W_DEF  = 8;
   localparam int unsigned FEAT_BUS_W = N_FEAT_DEF * FEAT_W_DEF;

endpackage

// File: rtl/adc_requant.sv
// Combinational requantizer: ADC_W-bit sample to FEAT_W bits, round-half-up with saturation.
module adc_requant
   import mlp_fe_pkg::*;
#(
   parameter int unsigned ADC_W  = ADC_W_DEF,
   parameter int unsigned FEAT_W = FEAT_W_DEF
) (
   input  logic [ADC_W-1:0]  adc_data,
   output logic [FEAT_W-1:0] q_c
);

   localparam int unsigned SUM_W = ADC_W + 1;
   localparam int unsigned SHIFT = ADC_W - FEAT_W;

   logic [SUM_W-1:0]  sum_c;
   logic [FEAT_W:0]   rnd_c;

   // Top FEAT_W+1 bits of the rounded sum are the shifted result; its MSB flags overflow.
   assign sum_c = {1'b0, adc_data} + SUM_W'(1 << (SHIFT - 1));
   assign rnd_c = sum_c[ADC_W -: FEAT_W + 1];
   assign q_c   = rnd_c[FEAT_W] ? '1 : rnd_c[FEAT_W-1:0];

endmodule

// File: rtl/mlp_adc_sequencer.sv
// Steps a shared ADC through all sensor channels, packs requantized features for the
// classifier, then latches the class index and offers it on a valid/ready handshake.
module mlp_adc_sequencer
   import mlp_fe_pkg::*;
#(
   parameter int unsigned N_FEAT      = N_FEAT_DEF,
   parameter int unsigned FEAT_W      = FEAT_W_DEF,
   parameter int unsigned ADC_W       = ADC_W_DEF,
   parameter int unsigned SETTLE_CYC  = 2,
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter int unsigned EVAL_CYC    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic [2:0]               adc_sel,
   output logic                     adc_req,
   input  logic                     adc_ack,
   input  logic [ADC_W-1:0]         adc_data,
   output logic [N_FEAT*FEAT_W-1:0] feat,
   input  logic [1:0]               cls_in,
   output logic [1:0]               cls_out,
   output logic                     cls_err,
   output logic                     cls_valid,
   input  logic                     cls_ready,
   output logic                     busy
);

   localparam int unsigned BUS_W   = N_FEAT * FEAT_W;
   localparam int unsigned CH_W    = 3;
   localparam int unsigned MAX_SE  = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
   localparam int unsigned CNT_MAX = (MAX_SE > TIMEOUT_CYC) ? MAX_SE : TIMEOUT_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_t             state_q, state_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic [FEAT_W-1:0]  shadow_q [N_FEAT];
   logic [FEAT_W-1:0]  shadow_d [N_FEAT];
   logic [BUS_W-1:0]   feat_q, feat_d;
   logic [1:0]         cls_out_q, cls_out_d;
   logic               cls_err_q, cls_err_d;
   logic               cls_valid_q, cls_valid_d;
   logic [CH_W-1:0]    adc_sel_q, adc_sel_d;
   logic               adc_req_q, adc_req_d;
   logic               busy_q, busy_d;

   logic [FEAT_W-1:0]  samp_q_c;
   logic               capture_c;
   logic [FEAT_W-1:0]  slot_c;
   logic [BUS_W-1:0]   pack_c;

   adc_requant #(
      .ADC_W  (ADC_W),
      .FEAT_W (FEAT_W)
   ) u_requant (
      .adc_data (adc_data),
      .q_c      (samp_q_c)
   );

   // Next-state, counters, shadow capture and registered-output targets.
   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      shadow_d  = shadow_q;
      feat_d    = feat_q;
      cls_out_d = cls_out_q;
      cls_err_d = cls_err_q;
      capture_c = 1'b0;
      slot_c    = '0;
      pack_c    = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SETTLE;
               ch_d    = '0;
               cnt_d   = '0;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               state_d = ST_REQ;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_REQ: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            // TIMEOUT_CYC ackable cycles; the following WAIT cycle abandons the channel.
            if (adc_ack && (cnt_q < CNT_W'(TIMEOUT_CYC))) begin
               capture_c = 1'b1;
               slot_c    = samp_q_c;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
               capture_c = 1'b1;
               slot_c    = '0;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_EVAL: begin
            if (cnt_q == CNT_W'(EVAL_CYC - 1)) begin
               state_d   = ST_DONE;
               cnt_d     = '0;
               cls_out_d = cls_in;
               cls_err_d = err_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (cls_ready) begin
               state_d = ST_IDLE;
               err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (capture_c) begin
         shadow_d[ch_q] = slot_c;
         cnt_d          = '0;
         if (ch_q == CH_W'(N_FEAT - 1)) begin
            // Whole frame, including the slot just written, goes to the classifier at once.
            for (int unsigned i = 0; i < N_FEAT; i++) begin
               pack_c[FEAT_W*i +: FEAT_W] = shadow_d[i];
            end
            feat_d  = pack_c;
            ch_d    = '0;
            state_d = ST_EVAL;
         end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = ST_SETTLE;
         end
      end

      adc_sel_d   = ch_d;
      adc_req_d   = (state_d == ST_REQ);
      cls_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ch_q        <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         shadow_q    <= '{default: '0};
         feat_q      <= '0;
         cls_out_q   <= '0;
         cls_err_q   <= 1'b0;
         cls_valid_q <= 1'b0;
         adc_sel_q   <= '0;
         adc_req_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         shadow_q    <= shadow_d;
         feat_q      <= feat_d;
         cls_out_q   <= cls_out_d;
         cls_err_q   <= cls_err_d;
         cls_valid_q <= cls_valid_d;
         adc_sel_q   <= adc_sel_d;
         adc_req_q   <= adc_req_d;
         busy_q      <= busy_d;
      end
   end

   assign adc_sel   = adc_sel_q;
   assign adc_req   = adc_req_q;
   assign feat      = feat_q;
   assign cls_out   = cls_out_q;
   assign cls_err   = cls_err_q;
   assign cls_valid = cls_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mlp_adc_sequencer.sv
// Directed plus randomized frames against a per-frame reference built from the sequencer rules.
module tb_mlp_adc_sequencer;
   import mlp_fe_pkg::*;

   localparam int NF  = 6;
   localparam int SET = 2;
   localparam int TMO = 16;
   localparam int EV  = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [2:0]            adc_sel;
   logic                  adc_req;
   logic                  adc_ack;
   logic [7:0]            adc_data;
   logic [FEAT_BUS_W-1:0] feat;
   logic [1:0]            cls_in;
   logic [1:0]            cls_out;
   logic                  cls_err;
   logic                  cls_valid;
   logic                  cls_ready;
   logic                  busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] f_samp [NF];
   int         f_dly  [NF];

   mlp_adc_sequencer #(
      .N_FEAT      (NF),
      .FEAT_W      (4),
      .ADC_W       (8),
      .SETTLE_CYC  (SET),
      .TIMEOUT_CYC (TMO),
      .EVAL_CYC    (EV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .adc_sel   (adc_sel),
      .adc_req   (adc_req),
      .adc_ack   (adc_ack),
      .adc_data  (adc_data),
      .feat      (feat),
      .cls_in    (cls_in),
      .cls_out   (cls_out),
      .cls_err   (cls_err),
      .cls_valid (cls_valid),
      .cls_ready (cls_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Round-half-up to 4 bits with saturation, plain integer arithmetic.
   function automatic int qref(input int x);
      int r;
      r = (x + 8) / 16;
      return (r > 15) ? 15 : r;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_adc_sel"},   32'(adc_sel),   0);
      check({tag, "_adc_req"},   32'(adc_req),   0);
      check({tag, "_feat"},      32'(feat),      0);
      check({tag, "_cls_out"},   32'(cls_out),   0);
      check({tag, "_cls_err"},   32'(cls_err),   0);
      check({tag, "_cls_valid"}, 32'(cls_valid), 0);
      check({tag, "_busy"},      32'(busy),      0);
   endtask

   // One frame from IDLE. f_dly[i]: ack on that WAIT cycle (1 = immediate), 0 = never.
   task automatic run_frame(input bit noise, input bit late, input int hold);
      logic [23:0] old_feat, exp_feat;
      logic [1:0]  c;
      bit          exp_err, waiting, acked;
      int          extra, exp_rel, rel, valid_rel, ch, wn;
      exp_feat = '0;
      exp_err  = 1'b0;
      extra    = 0;
      for (int i = 0; i < NF; i++) begin
         if (f_dly[i] >= 1 && f_dly[i] <= TMO) begin
            exp_feat[4*i +: 4] = 4'(qref(int'(f_samp[i])));
            extra += f_dly[i] - 1;
         end else begin
            exp_err = 1'b1;
            extra  += TMO;
         end
      end
      exp_rel  = NF * (SET + 2) + EV + 1 + extra;
      c        = 2'($urandom);
      cls_in   = c;
      old_feat = feat;
      start    = 1'b1;
      tick;
      start     = 1'b0;
      rel       = 1;
      ch        = -1;
      wn        = 0;
      waiting   = 1'b0;
      valid_rel = -1;
      while (rel < 500 && valid_rel < 0) begin
         adc_ack  = 1'b0;
         adc_data = 8'($urandom);
         start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         acked    = 1'b0;
         if (cls_valid) begin
            valid_rel = rel;
         end else begin
            if (adc_req) begin
               ch++;
               check("adc_sel", 32'(adc_sel), 32'(ch));
               waiting = 1'b1;
               wn      = 0;
            end else if (waiting && ch < NF) begin
               wn++;
               if (f_dly[ch] == wn || (late && f_dly[ch] == 0 && wn == TMO + 1)) begin
                  adc_ack  = 1'b1;
                  adc_data = f_samp[ch];
                  acked    = 1'b1;
                  if (f_dly[ch] != 0) waiting = 1'b0;
               end
            end
            if (noise && !acked && (!waiting || adc_req)) adc_ack = 1'($urandom_range(0, 1));
            check("feat_atomic", 32'(feat === old_feat || feat === exp_feat), 1);
            tick;
            rel++;
         end
      end
      check("valid_cycle", 32'(valid_rel), 32'(exp_rel));
      check("feat",        32'(feat),      32'(exp_feat));
      check("cls_out",     32'(cls_out),   32'(c));
      check("cls_err",     32'(cls_err),   32'(exp_err));
      check("busy_done",   32'(busy),      1);
      for (int h = 0; h < hold; h++) begin
         adc_ack   = 1'b0;
         cls_ready = 1'b0;
         start     = (h % 3 == 0);
         cls_in    = 2'($urandom);
         tick;
         check("hold_valid", 32'(cls_valid), 1);
         check("hold_out",   32'(cls_out),   32'(c));
         check("hold_err",   32'(cls_err),   32'(exp_err));
      end
      adc_ack   = 1'b0;
      start     = 1'b0;
      cls_ready = 1'b1;
      tick;
      cls_ready = 1'b0;
      check("valid_drop", 32'(cls_valid), 0);
      check("busy_idle",  32'(busy),      0);
      check("feat_keep",  32'(feat),      32'(exp_feat));
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      start     = 1'b0;
      adc_ack   = 1'b0;
      adc_data  = '0;
      cls_in    = '0;
      cls_ready = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      check_idle("reset");
      tick;
      check_idle("idle");

      // Quantizer boundaries: features 0,1,4,15,15,15.
      f_samp = '{8'h07, 8'h08, 8'h47, 8'hF7, 8'hF8, 8'hFF};
      f_dly  = '{1, 1, 1, 1, 1, 1};
      run_frame(1'b0, 1'b0, 0);
      check("quant_feat", 32'(feat), 32'h00FF_F410);

      // Full frame with default parameters.
      f_samp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
      run_frame(1'b0, 1'b0, 2);
      check("full_feat", 32'(feat), 32'h0065_4321);

      // Channel 3 never acked, late ack offered; result held 10 cycles with start pulses.
      f_samp = '{8'h10, 8'h20, 8'h30, 8'hC0, 8'h50, 8'h60};
      f_dly  = '{1, 1, 1, 0, 1, 1};
      run_frame(1'b0, 1'b1, 10);
      check("timeout_feat", 32'(feat), 32'h0065_0321);

      // Clean frame after the error frame.
      for (int i = 0; i < NF; i++) begin
         f_samp[i] = 8'($urandom);
         f_dly[i]  = $urandom_range(1, 4);
      end
      run_frame(1'b0, 1'b0, 1);

      // Reset during WAIT of channel 2 (no acks, so early channels time out).
      cls_in = 2'd3;
      start  = 1'b1;
      tick;
      start = 1'b0;
      n     = 0;
      while (!(adc_req && adc_sel == 3'd2) && n < 200) begin
         tick;
         n++;
      end
      check("reach_ch2", 32'(n < 200), 1);
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check_idle("midrst");
      for (int i = 0; i < NF; i++) begin
         f_samp[i] = 8'($urandom);
         f_dly[i]  = 1;
      end
      run_frame(1'b0, 1'b0, 0);

      // Randomized frames with ack noise outside WAIT and spurious starts.
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < NF; i++) begin
            f_samp[i] = 8'($urandom);
            f_dly[i]  = $urandom_range(1, 6);
         end
         if (k == 3) f_dly[$urandom_range(0, NF - 1)] = 0;
         run_frame(1'b1, (k == 3), $urandom_range(0, 4));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
